// File: rtl/fabric_pkg.sv
// Shared types and helpers for the fabric token path blocks.
package fabric_pkg;

  localparam int FABRIC_DATA_WIDTH = 32;
  localparam int FABRIC_TAG_WIDTH  = 4;

  typedef struct packed {
    logic [FABRIC_TAG_WIDTH-1:0]  tag;
    logic [FABRIC_DATA_WIDTH-1:0] data;
  } tagged_token_t;

  // Index width for a power-of-two depth; callers add one bit for the wrap flag.
  function automatic int clog2_pow2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fabric_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; write visible at head one cycle later.
// Push while full and pop while empty are ignored; no bypass path.
module fabric_sync_fifo
  import fabric_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = clog2_pow2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same slot on opposite laps means full; identical pointers mean empty.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fabric_del_tag_buf.sv
// Strips the tag from fabric tokens and buffers payloads; 1-cycle latency, no comb in->out path.
// in_ready tracks FIFO occupancy only; optional tag filter drops and counts mismatches.
module fabric_del_tag_buf
  import fabric_pkg::*;
#(
  parameter int DATA_WIDTH = FABRIC_DATA_WIDTH,
  parameter int TAG_WIDTH  = FABRIC_TAG_WIDTH,
  parameter int DEPTH      = 4,
  parameter int FILTER_EN  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]          cfg_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          err_sticky,
  input  logic                          err_clr
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } tok_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  tok_t                 tok;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 tag_ok;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 err_sticky_q, err_sticky_d;

  assign tok       = tok_t'(in_data);
  // Held low during reset so upstream never sees a handshake while the buffer is being flushed.
  assign in_ready  = !fifo_full && !rst;
  assign accept    = in_valid && in_ready;
  assign tag_ok    = (FILTER_EN == 0) || (tok.tag == cfg_tag);
  assign push      = accept && tag_ok;
  assign drop      = accept && !tag_ok;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  fabric_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (tok.data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (out_data)
  );

  // Clear applies first so a drop in the same cycle is still recorded.
  always_comb begin
    drop_count_d = err_clr ? '0 : drop_count_q;
    err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
    if (drop) begin
      if (drop_count_d != CNT_MAX) drop_count_d = drop_count_d + CNT_WIDTH'(1);
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign drop_count = drop_count_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fabric_del_tag_buf.sv
// Three instances (strip-only, filter, filter with 2-bit counter) share one stimulus stream;
// a queue-based reference model per instance feeds a negedge monitor.
module tb_fabric_del_tag_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [35:0] in_data;
  logic [3:0]  cfg_tag;
  logic        out_ready;
  logic        err_clr;

  logic [2:0]  in_rdy;
  logic [2:0]  out_vld;
  logic [2:0]  err_s;
  logic [31:0] od0, od1, od2;
  logic [15:0] dc0, dc1;
  logic [1:0]  dc2;

  int checks = 0;
  int errors = 0;

  int          occ   [3];
  int unsigned mdc   [3];
  bit          merr  [3];
  logic [31:0] exp_q [3][$];
  bit          filt  [3] = '{1'b0, 1'b1, 1'b1};
  int unsigned cmax  [3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  fabric_del_tag_buf #(.DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(DEPTH), .FILTER_EN(0), .CNT_WIDTH(16)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .cfg_tag(cfg_tag), .out_valid(out_vld[0]), .out_ready(out_ready), .out_data(od0),
    .drop_count(dc0), .err_sticky(err_s[0]), .err_clr(err_clr));

  fabric_del_tag_buf #(.DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(DEPTH), .FILTER_EN(1), .CNT_WIDTH(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .cfg_tag(cfg_tag), .out_valid(out_vld[1]), .out_ready(out_ready), .out_data(od1),
    .drop_count(dc1), .err_sticky(err_s[1]), .err_clr(err_clr));

  fabric_del_tag_buf #(.DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(DEPTH), .FILTER_EN(1), .CNT_WIDTH(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_data(in_data),
    .cfg_tag(cfg_tag), .out_valid(out_vld[2]), .out_ready(out_ready), .out_data(od2),
    .drop_count(dc2), .err_sticky(err_s[2]), .err_clr(err_clr));

  function automatic logic [31:0] get_od(input int i);
    case (i)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [31:0] get_dc(input int i);
    case (i)
      0:       return {16'd0, dc0};
      1:       return {16'd0, dc1};
      default: return {30'd0, dc2};
    endcase
  endfunction

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, occupancy as a count.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        occ[i]  = 0;
        mdc[i]  = 0;
        merr[i] = 1'b0;
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit acc, popm, ok;
        acc  = in_valid && (occ[i] < DEPTH);
        popm = out_ready && (occ[i] > 0);
        if (err_clr) begin
          mdc[i]  = 0;
          merr[i] = 1'b0;
        end
        if (acc) begin
          ok = !filt[i] || (in_data[35:32] == cfg_tag);
          if (ok) begin
            exp_q[i].push_back(in_data[31:0]);
            occ[i]++;
          end else begin
            if (mdc[i] < cmax[i]) mdc[i]++;
            merr[i] = 1'b1;
          end
        end
        if (popm) occ[i]--;
      end
    end
  end

  // Monitor: compares every instance against the model away from the clock edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk(i, "rst out_valid", {31'd0, out_vld[i]}, 32'd0);
        chk(i, "rst in_ready", {31'd0, in_rdy[i]}, 32'd0);
      end else begin
        chk(i, "in_ready", {31'd0, in_rdy[i]}, {31'd0, occ[i] < DEPTH});
        chk(i, "out_valid", {31'd0, out_vld[i]}, {31'd0, occ[i] > 0});
        chk(i, "drop_count", get_dc(i), mdc[i]);
        chk(i, "err_sticky", {31'd0, err_s[i]}, {31'd0, merr[i]});
        if (out_vld[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(i, "unexpected output", get_od(i), 32'hxxxxxxxx);
          end else begin
            chk(i, "out_data", get_od(i), exp_q[i][0]);
            if (out_ready) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] tag, input logic [31:0] data);
    in_valid = 1'b1;
    in_data  = {tag, data};
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_tag   = 4'd3;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single token, one-cycle latency.
    out_ready = 1'b1;
    send(4'hA, 32'hDEADBEEF);
    chk(0, "t1 out_valid", {31'd0, out_vld[0]}, 32'd1);
    chk(0, "t1 out_data", od0, 32'hDEADBEEF);
    chk(0, "t1 drop_count", {16'd0, dc0}, 32'd0);
    chk(1, "t1 filtered out_valid", {31'd0, out_vld[1]}, 32'd0);
    repeat (2) cyc();

    // Fill to full with consumer stalled, then drain.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(4'h0, k);
    chk(0, "t2 full in_ready", {31'd0, in_rdy[0]}, 32'd0);
    out_ready = 1'b1;
    cyc();
    chk(0, "t2 in_ready after pop", {31'd0, in_rdy[0]}, 32'd1);
    repeat (5) cyc();

    // Streaming: one token per cycle, no bubbles.
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = {4'h0, 32'(100 + k)};
      cyc();
      chk(0, "t3 no bubble", {31'd0, out_vld[0]}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) cyc();

    // Filtering and sticky error clear.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    send(4'd3, 32'd11);
    send(4'd5, 32'd22);
    send(4'd3, 32'd33);
    send(4'd7, 32'd44);
    chk(1, "t4 drop_count", {16'd0, dc1}, 32'd2);
    chk(1, "t4 err_sticky", {31'd0, err_s[1]}, 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk(1, "t4 cleared count", {16'd0, dc1}, 32'd0);
    chk(1, "t4 cleared err", {31'd0, err_s[1]}, 32'd0);

    // Clear and drop in the same cycle.
    err_clr  = 1'b1;
    in_valid = 1'b1;
    in_data  = {4'd5, 32'd77};
    cyc();
    err_clr  = 1'b0;
    in_valid = 1'b0;
    chk(1, "clr+drop count", {16'd0, dc1}, 32'd1);
    chk(1, "clr+drop err", {31'd0, err_s[1]}, 32'd1);

    // Counter saturation on the 2-bit instance.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    for (int k = 0; k < 5; k++) send(4'd9, 32'(200 + k));
    chk(2, "t5 saturated", {30'd0, dc2}, 32'd3);
    send(4'd9, 32'd250);
    chk(2, "t5 held", {30'd0, dc2}, 32'd3);
    repeat (6) cyc();

    // Reset mid-transfer.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(4'd3, 32'(300 + k));
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(i, "t6 rst out_valid", {31'd0, out_vld[i]}, 32'd0);
      chk(i, "t6 rst in_ready", {31'd0, in_rdy[i]}, 32'd0);
    end
    cyc();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(4'd3, 32'd55);
    chk(0, "t6 token after reset", od0, 32'd55);
    chk(0, "t6 valid after reset", {31'd0, out_vld[0]}, 32'd1);
    cyc();
    chk(0, "t6 alone", {31'd0, out_vld[0]}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd3, 32'($urandom)};
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
